// File: rtl/system_unit.sv
// system_unit: SYSTEM-class execute responder (cycle/time/instret counters, RD* reads, SCALL/SBREAK trap request).
// Optional feature macro SYSUNIT_SNAPSHOT_EN: low reads latch the upper half into per-counter shadows for tear-free H reads.
module system_unit #(
  parameter int unsigned TIME_DIV = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [3:0]  i_sysop,
  input  logic        i_stall,
  input  logic        i_retire,
  input  logic        i_trap_ack,
  output logic        o_ready,
  output logic [31:0] o_result,
  output logic        o_result_valid,
  output logic        o_trap_req,
  output logic        o_trap_cause
);
  localparam logic [3:0] OP_RDCYCLE    = 4'd0;
  localparam logic [3:0] OP_RDCYCLEH   = 4'd1;
  localparam logic [3:0] OP_RDTIME     = 4'd2;
  localparam logic [3:0] OP_RDTIMEH    = 4'd3;
  localparam logic [3:0] OP_RDINSTRET  = 4'd4;
  localparam logic [3:0] OP_RDINSTRETH = 4'd5;
  localparam logic [3:0] OP_SCALL      = 4'd6;
  localparam logic [3:0] OP_SBREAK     = 4'd7;
  localparam logic [15:0] DIV_M1 = 16'(TIME_DIV - 32'd1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd1, S_TRAP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [63:0] cycle_q, cycle_d, time_q, time_d, instret_q, instret_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] result_q, result_d, rd_data_s;
  logic        ready_q, valid_q, trap_q, cause_q, cause_d;
  logic        accept_s, is_trap_s, hi_s;
  logic [1:0]  sel_s;
  logic [63:0] live_s;

  assign accept_s = i_valid & ready_q & ~i_stall;

  // Free-running counters; time advances when the prescaler wraps.
  always_comb begin
    cycle_d = cycle_q + 64'd1;
    if (i_retire) instret_d = instret_q + 64'd1;
    else          instret_d = instret_q;
    if (presc_q == DIV_M1) begin
      presc_d = 16'd0;
      time_d  = time_q + 64'd1;
    end else begin
      presc_d = presc_q + 16'd1;
      time_d  = time_q;
    end
  end

  // Operation decode; unknown encodings fall through to RDCYCLE.
  always_comb begin
    sel_s     = 2'd0;
    hi_s      = 1'b0;
    is_trap_s = 1'b0;
    case (i_sysop)
      OP_RDCYCLEH:   hi_s = 1'b1;
      OP_RDTIME:     sel_s = 2'd1;
      OP_RDTIMEH:    begin sel_s = 2'd1; hi_s = 1'b1; end
      OP_RDINSTRET:  sel_s = 2'd2;
      OP_RDINSTRETH: begin sel_s = 2'd2; hi_s = 1'b1; end
      OP_SCALL,
      OP_SBREAK:     is_trap_s = 1'b1;
      default:       begin sel_s = 2'd0; hi_s = 1'b0; end
    endcase
    case (sel_s)
      2'd1:    live_s = time_q;
      2'd2:    live_s = instret_q;
      default: live_s = cycle_q;
    endcase
  end

`ifdef SYSUNIT_SNAPSHOT_EN
  logic [2:0][31:0] shadow_q, shadow_d;

  // Low reads capture the upper half so the following H read is consistent.
  always_comb begin
    shadow_d = shadow_q;
    if (accept_s && !is_trap_s && !hi_s) shadow_d[sel_s] = live_s[63:32];
    else                                 shadow_d = shadow_q;
    if (hi_s) rd_data_s = shadow_q[sel_s];
    else      rd_data_s = live_s[31:0];
  end

  // Shadow registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) shadow_q <= 96'd0;
    else          shadow_q <= shadow_d;
  end
`else
  // Live read path.
  always_comb begin
    if (hi_s) rd_data_s = live_s[63:32];
    else      rd_data_s = live_s[31:0];
  end
`endif

  // Next state, captured read data and trap cause.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cause_d  = cause_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && is_trap_s) begin
          state_d = S_TRAP;
          cause_d = (i_sysop == OP_SBREAK);
        end else if (accept_s) begin
          state_d  = S_RESP;
          result_d = rd_data_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: state_d = S_IDLE;
      S_TRAP: begin
        if (i_trap_ack) state_d = S_IDLE;
        else            state_d = S_TRAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cycle_q   <= 64'd0;
      time_q    <= 64'd0;
      instret_q <= 64'd0;
      presc_q   <= 16'd0;
      result_q  <= 32'd0;
      cause_q   <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      time_q    <= time_d;
      instret_q <= instret_d;
      presc_q   <= presc_d;
      result_q  <= result_d;
      cause_q   <= cause_d;
      ready_q   <= (state_d == S_IDLE);
      valid_q   <= (state_d == S_RESP);
      trap_q    <= (state_d == S_TRAP);
    end
  end

  assign o_ready        = ready_q;
  assign o_result       = result_q;
  assign o_result_valid = valid_q;
  assign o_trap_req     = trap_q;
  assign o_trap_cause   = cause_q;
endmodule

// File: tb/tb_system_unit.sv
// Scoreboard bench for system_unit: counters modelled arithmetically from cycles since reset, checked by a monitor.
module tb_system_unit;
  localparam int unsigned TDIV = 4;
`ifdef SYSUNIT_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, valid = 1'b0, stall = 1'b0, retire = 1'b0, ack = 1'b0;
  logic [3:0]  sysop = 4'd0;
  logic        o_ready, o_result_valid, o_trap_req, o_trap_cause;
  logic [31:0] o_result;

  always #5 clk = ~clk;

  system_unit #(.TIME_DIV(TDIV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sysop(sysop), .i_stall(stall),
    .i_retire(retire), .i_trap_ack(ack), .o_ready(o_ready), .o_result(o_result),
    .o_result_valid(o_result_valid), .o_trap_req(o_trap_req), .o_trap_cause(o_trap_cause));

  int errors = 0, checks = 0;
  typedef struct { bit is_trap; logic [31:0] val; } exp_t;
  exp_t sb[$];

  // reference model: elapsed cycles and retirements since reset
  longint unsigned cyc_n = 0, ins_n = 0, cyc_off = 0;
  logic [31:0] sh_c = 32'd0, sh_t = 32'd0, sh_i = 32'd0;
  bit rnd_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin cyc_n = 0; ins_n = 0; end
    else begin cyc_n = cyc_n + 1; if (retire) ins_n = ins_n + 1; end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected read value at the current (accept) cycle; also updates the shadow model.
  function automatic logic [31:0] model_read(logic [3:0] op);
    logic [63:0] c, t, n;
    logic [31:0] r;
    c = cyc_n + cyc_off;
    t = cyc_n / TDIV;
    n = ins_n;
    case (op)
      4'd1:    r = SNAP ? sh_c : c[63:32];
      4'd2:    begin r = t[31:0]; sh_t = t[63:32]; end
      4'd3:    r = SNAP ? sh_t : t[63:32];
      4'd4:    begin r = n[31:0]; sh_i = n[63:32]; end
      4'd5:    r = SNAP ? sh_i : n[63:32];
      default: begin r = c[31:0]; sh_c = c[63:32]; end
    endcase
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever a result or a new trap request appears.
  logic trap_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_result_valid) begin
        if (sb.size() == 0 || sb[0].is_trap) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %0h expected no result", o_result);
        end else begin
          e = sb.pop_front();
          chk("read_value", {32'd0, o_result}, {32'd0, e.val});
        end
      end
      if (o_trap_req && !trap_prev) begin
        if (sb.size() == 0 || !sb[0].is_trap) begin
          checks++; errors++;
          $display("FAIL unexpected_trap: got cause %0d expected no trap", o_trap_cause);
        end else begin
          e = sb.pop_front();
          chk("trap_cause", {63'd0, o_trap_cause}, {32'd0, e.val});
        end
      end
    end
    trap_prev = o_trap_req;
  end

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; stall = 1'b0; retire = 1'b0; ack = 1'b0;
    #1;
    chk("rst_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_trap_req", {63'd0, o_trap_req}, 64'd0);
    chk("rst_result_valid", {63'd0, o_result_valid}, 64'd0);
    sb.delete();
    cyc_off = 0; sh_c = 32'd0; sh_t = 32'd0; sh_i = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue a read at the current negedge with nstall stalled cycles first.
  task automatic issue(logic [3:0] op, int nstall, bit use_c, logic [31:0] cval);
    exp_t e;
    valid = 1'b1; sysop = op;
    for (int i = 0; i < nstall; i++) begin
      stall = 1'b1; retire = rnd_on ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      chk("stall_ready", {63'd0, o_ready}, 64'd1);
    end
    stall = 1'b0; retire = rnd_on ? 1'($urandom_range(0, 1)) : 1'b0;
    e.is_trap = 1'b0;
    e.val = model_read(op);
    if (use_c) e.val = cval;
    sb.push_back(e);
    @(negedge clk);
    valid = 1'b0; retire = 1'b0;
    chk("resp_ready", {63'd0, o_ready}, 64'd0);
    @(negedge clk);
    chk("post_resp_ready", {63'd0, o_ready}, 64'd1);
  endtask

  task automatic trap(logic [3:0] op, int hold, bit attempt);
    exp_t e;
    valid = 1'b1; sysop = op; stall = 1'b0;
    e.is_trap = 1'b1; e.val = {31'd0, op == 4'd7};
    sb.push_back(e);
    @(negedge clk);
    valid = 1'b0;
    chk("trap_req", {63'd0, o_trap_req}, 64'd1);
    chk("trap_ready", {63'd0, o_ready}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      valid = attempt && (i == 1); sysop = 4'd0;
      @(negedge clk);
      chk("trap_held", {63'd0, o_trap_req}, 64'd1);
    end
    valid = 1'b0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("trap_drop", {63'd0, o_trap_req}, 64'd0);
    chk("trap_idle_ready", {63'd0, o_ready}, 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_result", {32'd0, o_result}, 64'd0);
    chk("rst_cause", {63'd0, o_trap_cause}, 64'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(4'd0, 0, 1'b1, 32'd10);

    do_reset();
    repeat (41) @(negedge clk);
    issue(4'd2, 0, 1'b1, 32'd10);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      retire = 1'b1; @(negedge clk);
      retire = 1'b0; @(negedge clk);
    end
    issue(4'd4, 3, 1'b1, 32'd7);

    trap(4'd7, 5, 1'b1);
    trap(4'd6, 0, 1'b0);

    force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cycle_q;
    cyc_off = 64'h0000_0000_FFFF_FFFE - cyc_n;
    issue(4'd0, 0, 1'b1, 32'hFFFF_FFFE);
    issue(4'd1, 0, 1'b1, SNAP ? 32'd0 : 32'd1);

    valid = 1'b1; sysop = 4'd6;
    begin
      exp_t e;
      e.is_trap = 1'b1; e.val = 32'd0;
      sb.push_back(e);
    end
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    issue(4'd5, 0, 1'b1, 32'd0);
    issue(4'hB, 1, 1'b0, 32'd0);

    rnd_on = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) begin
        retire = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      retire = 1'b0;
      if (op == 4'd6 || op == 4'd7) trap(op, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else issue(op, $urandom_range(0, 2), 1'b0, 32'd0);
    end

    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
